// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - runtime-configurable UART transmitter
//
// Purpose:
//   Serialises one character per tx_valid/tx_ready handshake, LSB first.
//   The data length (5..DATA_W), the parity (none/even/odd) and the stop
//   bit count (1/2) are captured together with the character on accept.
//   Bit timing comes from an external oversampling tick: OSR baud_tick
//   pulses make one bit period. baud_rst holds that tick generator in reset
//   while the transmitter is idle, so every frame starts on a fresh phase.
//
// Ports:
//   clk            system clock
//   rst_n          synchronous active-low reset
//   baud_tick      one-cycle oversampling pulse, OSR per bit
//   tx_data_i      character, bits above the data length are ignored
//   tx_valid       character and cfg_* are valid
//   tx_ready       idle, a character can be accepted
//   cfg_data_bits  data bits per frame, out of range values select DATA_W
//   cfg_parity     00 none, 01 even, 10 odd, 11 none
//   cfg_stop2      0 one stop bit, 1 two stop bits
//   tx             serial line, idle high
//   tx_busy        frame in progress
//   tx_done        one-cycle pulse after the last stop bit
//   baud_rst       high while idle

module uart_tx_cfg #(
  parameter int DATA_W = 8,
  parameter int OSR    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              baud_tick,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [3:0]        cfg_data_bits,
  input  logic [1:0]        cfg_parity,
  input  logic              cfg_stop2,
  output logic              tx,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              baud_rst
);

  localparam int CW = (OSR > 2) ? $clog2(OSR) : 1;
  localparam logic [CW-1:0] TICK_MAX = CW'(OSR - 1);
  localparam logic [3:0]    DW4      = 4'(DATA_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t            state;
  logic [CW-1:0]     tick_cnt;
  logic [3:0]        bit_cnt;
  logic [3:0]        n_bits;
  logic [DATA_W-1:0] shift_reg;
  logic              par_en;
  logic              par_bit;
  logic              stop2;
  logic              stop_cnt;

  logic [3:0]        acc_bits;
  logic [DATA_W-1:0] acc_data;
  logic              acc_par;
  logic              accept;
  logic              bit_end;

  // Capture-time view of the request: clamped length, masked data and the
  // parity bit, so nothing about the frame depends on inputs after accept.
  always_comb begin
    acc_bits = cfg_data_bits;
    if (cfg_data_bits < 4'd5 || cfg_data_bits > DW4) begin
      acc_bits = DW4;
    end
    acc_data = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (4'(i) < acc_bits) begin
        acc_data[i] = tx_data_i[i];
      end
    end
    acc_par = (^acc_data) ^ (cfg_parity == 2'b10);
  end

  assign accept  = tx_valid && tx_ready;
  assign bit_end = baud_tick && (tick_cnt == TICK_MAX);

  // Single FSM; every output is a register so tx never sees an input
  // combinationally. tx is loaded with the level of the next bit on the
  // edge that ends the current one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      n_bits    <= '0;
      shift_reg <= '0;
      par_en    <= 1'b0;
      par_bit   <= 1'b0;
      stop2     <= 1'b0;
      stop_cnt  <= 1'b0;
      tx        <= 1'b1;
      tx_ready  <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
      baud_rst  <= 1'b1;
    end else begin
      tx_done <= 1'b0;

      if (state != S_IDLE && baud_tick) begin
        tick_cnt <= (tick_cnt == TICK_MAX) ? '0 : tick_cnt + 1'b1;
      end

      case (state)
        S_IDLE: begin
          tick_cnt <= '0;
          if (accept) begin
            shift_reg <= acc_data;
            n_bits    <= acc_bits;
            par_en    <= (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
            par_bit   <= acc_par;
            stop2     <= cfg_stop2;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            state     <= S_START;
            tx        <= 1'b0;
            tx_ready  <= 1'b0;
            tx_busy   <= 1'b1;
            baud_rst  <= 1'b0;
          end
        end

        S_START: begin
          if (bit_end) begin
            state <= S_DATA;
            tx    <= shift_reg[0];
          end
        end

        S_DATA: begin
          if (bit_end) begin
            shift_reg <= shift_reg >> 1;
            bit_cnt   <= bit_cnt + 4'd1;
            if (bit_cnt + 4'd1 == n_bits) begin
              if (par_en) begin
                state <= S_PARITY;
                tx    <= par_bit;
              end else begin
                state <= S_STOP;
                tx    <= 1'b1;
              end
            end else begin
              tx <= shift_reg[1];
            end
          end
        end

        S_PARITY: begin
          if (bit_end) begin
            state <= S_STOP;
            tx    <= 1'b1;
          end
        end

        S_STOP: begin
          if (bit_end) begin
            if (stop2 && !stop_cnt) begin
              stop_cnt <= 1'b1;
            end else begin
              state    <= S_IDLE;
              tx       <= 1'b1;
              tx_ready <= 1'b1;
              tx_busy  <= 1'b0;
              baud_rst <= 1'b1;
              tx_done  <= 1'b1;
            end
          end
        end

        default: begin
          state    <= S_IDLE;
          tx       <= 1'b1;
          tx_ready <= 1'b1;
          tx_busy  <= 1'b0;
          baud_rst <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - randomized self-checking bench for uart_tx_cfg
//
// Purpose:
//   Builds the expected bit list of every frame from the character and the
//   configuration, then compares the line and status outputs every cycle
//   against the bit selected by the number of baud ticks seen since accept.
//
// Ports: none (top-level bench).

module tb_uart_tx_cfg;

  localparam int DATA_W = 8;
  localparam int OSR    = 16;

  logic              clk;
  logic              rst_n;
  logic              baud_tick;
  logic [DATA_W-1:0] tx_data_i;
  logic              tx_valid;
  logic              tx_ready;
  logic [3:0]        cfg_data_bits;
  logic [1:0]        cfg_parity;
  logic              cfg_stop2;
  logic              tx;
  logic              tx_busy;
  logic              tx_done;
  logic              baud_rst;

  int n_checks = 0;
  int n_bad    = 0;
  int tph      = 0;
  int period   = 1;

  uart_tx_cfg #(.DATA_W(DATA_W), .OSR(OSR)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .baud_tick     (baud_tick),
    .tx_data_i     (tx_data_i),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .cfg_data_bits (cfg_data_bits),
    .cfg_parity    (cfg_parity),
    .cfg_stop2     (cfg_stop2),
    .tx            (tx),
    .tx_busy       (tx_busy),
    .tx_done       (tx_done),
    .baud_rst      (baud_rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_tick();
    baud_tick = ((tph % period) == 0);
    tph++;
  endtask

  // Tasks start and end just after a falling edge, before the inputs for
  // the next rising edge have been driven.
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      tx_valid = 1'b0;
      drive_tick();
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // junk: hold tx_valid high with 0xFF during the frame (must be ignored).
  // abort_t: if nonzero, pulse reset once that many ticks have elapsed.
  task automatic frame(input logic [7:0] d, input logic [3:0] nb, input logic [1:0] par,
                       input logic s2, input bit junk, input int abort_t);
    logic bits[$];
    logic p;
    logic tk;
    logic [4:0] exp_v;
    int n;
    int len;
    int t;

    n = (nb < 4'd5 || nb > 4'd8) ? 8 : int'(nb);
    bits = {};
    bits.push_back(1'b0);
    p = 1'b0;
    for (int i = 0; i < n; i++) begin
      bits.push_back(d[i]);
      p = p ^ d[i];
    end
    if (par == 2'b01) bits.push_back(p);
    if (par == 2'b10) bits.push_back(~p);
    bits.push_back(1'b1);
    if (s2) bits.push_back(1'b1);
    len = bits.size();

    check("pre_ready", {31'd0, tx_ready}, 32'd1);
    check("pre_tx", {31'd0, tx}, 32'd1);
    tx_data_i     = d;
    cfg_data_bits = nb;
    cfg_parity    = par;
    cfg_stop2     = s2;
    tx_valid      = 1'b1;
    drive_tick();
    @(posedge clk);
    t = 0;

    forever begin
      @(negedge clk);
      if (t < OSR * len) exp_v = {bits[t / OSR], 4'b1000};
      else               exp_v = 5'b10111;
      check("line", {27'd0, tx, tx_busy, tx_ready, tx_done, baud_rst}, {27'd0, exp_v});
      if (t >= OSR * len) begin
        tx_valid = 1'b0;
        return;
      end
      if (abort_t > 0 && t == abort_t) begin
        rst_n    = 1'b0;
        tx_valid = 1'b0;
        drive_tick();
        @(posedge clk);
        @(negedge clk);
        check("rst_abort", {27'd0, tx, tx_busy, tx_ready, tx_done, baud_rst}, 32'b10101);
        rst_n = 1'b1;
        return;
      end
      tx_valid      = junk;
      tx_data_i     = junk ? 8'hFF : 8'($urandom);
      cfg_data_bits = 4'($urandom);
      cfg_parity    = 2'($urandom);
      cfg_stop2     = 1'($urandom);
      drive_tick();
      tk = baud_tick;
      @(posedge clk);
      t += int'(tk);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    baud_tick     = 1'b0;
    tx_data_i     = '0;
    tx_valid      = 1'b0;
    cfg_data_bits = 4'd8;
    cfg_parity    = 2'b00;
    cfg_stop2     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset", {27'd0, tx, tx_busy, tx_ready, tx_done, baud_rst}, 32'b10101);
    rst_n = 1'b1;
    idle(3);

    period = 1;
    frame(8'hA5, 4'd8, 2'b00, 1'b0, 1'b0, 0);
    idle(2);
    frame(8'h41, 4'd7, 2'b01, 1'b0, 1'b0, 0);
    frame(8'h41, 4'd7, 2'b10, 1'b0, 1'b0, 0);
    idle(1);
    frame(8'hFF, 4'd5, 2'b00, 1'b1, 1'b0, 0);
    idle(1);

    period = 3;
    frame(8'h3C, 4'd8, 2'b00, 1'b0, 1'b1, 0);
    frame(8'h3C, 4'd8, 2'b00, 1'b0, 1'b0, 0);
    idle(2);

    period = 1;
    frame(8'hC3, 4'd4, 2'b00, 1'b0, 1'b0, 0);
    frame(8'h5A, 4'd8, 2'b11, 1'b0, 1'b0, 0);
    idle(1);
    frame(8'h96, 4'd8, 2'b00, 1'b0, 1'b0, OSR * 4 + 6);
    frame(8'h55, 4'd8, 2'b00, 1'b0, 1'b0, 0);

    for (int k = 0; k < 12; k++) begin
      period = $urandom_range(1, 3);
      idle($urandom_range(0, 2));
      frame(8'($urandom), 4'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 0);
    end
    idle(2);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
